// File: rtl/dds_pkg.sv
// Shared constants and FSM state encoding for the DDS frequency demodulator.
package dds_pkg;

  localparam int ACC_W_DEF    = 8;
  localparam int AVG_LOG2_DEF = 2;
  localparam int WORD_W       = 4;
  localparam int WORD_MAX     = (1 << WORD_W) - 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GATE   = 2'd1,
    REPORT = 2'd2
  } dds_state_t;

endpackage

// File: rtl/dds_edge_det.sv
// Rising-edge detector on the DDS sign bit; a rise must stay high for two
// sampled cycles before it produces a single-cycle pulse.
module dds_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic edge_pulse
);

  // hist[2] is the oldest sample
  logic [2:0] hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= 3'b000;
    end else begin
      hist <= {hist[1:0], in};
    end
  end

  assign edge_pulse = (hist == 3'b011);

endmodule

// File: rtl/dds_demod.sv
// Recovers the DDS tuning word by counting sign-bit rising edges over a gate
// of 2^(ACC_W+AVG_LOG2) cycles, and tracks the peak magnitude in that gate.
//
// state  | meaning
// IDLE   | waiting for en
// GATE   | counting edges and peak magnitude
// REPORT | rounding the count; results publish next cycle
module dds_demod
  import dds_pkg::*;
#(
  parameter int ACC_W    = ACC_W_DEF,
  parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [7:0]        in_mag,
  input  logic              in_sym,
  output logic [WORD_W-1:0] freq_word,
  output logic              freq_valid,
  output logic              locked,
  output logic [7:0]        amp,
  output logic              ovf
);

  localparam int GATE_W    = ACC_W + AVG_LOG2;
  localparam int EDGE_W    = WORD_W + AVG_LOG2 + 1;
  localparam int ROUND_ADD = (AVG_LOG2 > 0) ? (1 << (AVG_LOG2 - 1)) : 0;
  localparam logic [GATE_W-1:0] GATE_LAST = '1;
  localparam logic [EDGE_W-1:0] EDGE_SAT  = '1;

  dds_state_t state, state_nxt;

  logic [GATE_W-1:0] gate_cnt;
  logic [EDGE_W-1:0] edge_cnt;
  logic [7:0]        peak;
  logic              edge_pulse;
  logic              gate_start;
  logic              abort;
  logic              report;
  logic              have_prev;

  logic [EDGE_W:0]     rnd_sum;
  logic [EDGE_W:0]     rnd_q;
  logic                sat;
  logic [WORD_W-1:0]   word_nxt;

  dds_edge_det u_edge_det (
    .clk        (clk),
    .rst_n      (rst_n),
    .in         (in_sym),
    .edge_pulse (edge_pulse)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    gate_start = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_nxt  = GATE;
          gate_start = 1'b1;
        end
      end
      GATE: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (gate_cnt == GATE_LAST) begin
          state_nxt = REPORT;
        end
      end
      REPORT: begin
        if (en) begin
          state_nxt  = GATE;
          gate_start = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign abort  = (state == GATE) && !en;
  assign report = (state == REPORT);

  // Gate datapath: cleared on every gate entry, so a new gate can start in
  // the same edge that publishes the previous one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      peak     <= '0;
    end else if (gate_start) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      peak     <= '0;
    end else if (state == GATE) begin
      gate_cnt <= gate_cnt + GATE_W'(1);
      if (edge_pulse && (edge_cnt != EDGE_SAT)) begin
        edge_cnt <= edge_cnt + EDGE_W'(1);
      end
      if (in_mag > peak) begin
        peak <= in_mag;
      end
    end
  end

  assign rnd_sum  = {1'b0, edge_cnt} + (EDGE_W + 1)'(ROUND_ADD);
  assign rnd_q    = rnd_sum >> AVG_LOG2;
  assign sat      = (rnd_q > (EDGE_W + 1)'(WORD_MAX));
  assign word_nxt = sat ? WORD_W'(WORD_MAX) : rnd_q[WORD_W-1:0];

  // have_prev marks that freq_word holds an estimate from an unbroken run,
  // so the first result after reset or abort can never lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_word  <= '0;
      freq_valid <= 1'b0;
      locked     <= 1'b0;
      amp        <= '0;
      ovf        <= 1'b0;
      have_prev  <= 1'b0;
    end else begin
      freq_valid <= report;
      if (report) begin
        freq_word <= word_nxt;
        ovf       <= sat;
        amp       <= peak;
        locked    <= have_prev && (word_nxt == freq_word) && !sat;
        have_prev <= 1'b1;
      end else if (abort) begin
        have_prev <= 1'b0;
      end
    end
  end

endmodule

// File: doc/dds_demod.md
DDS_DEMOD -- requirements
Module: dds_demod

Interface
REQ-001 Parameter ACC_W, default 8: phase-accumulator width of the companion DDS; one output period = 2^ACC_W / tuning word clock cycles.
REQ-002 Parameter AVG_LOG2, default 2: log2 of the number of accumulator wraps per measurement gate; gate length G = 2^(ACC_W+AVG_LOG2) cycles (1024 at defaults).
REQ-003 clk  input  1  single system clock; all logic samples on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  measurement enable; high = run gates continuously.
REQ-006 in_mag  input  8  DDS folded magnitude sample, one per clock.
REQ-007 in_sym  input  1  DDS half-wave sign bit, one per clock.
REQ-008 freq_word  output  4  recovered tuning word (matches the DDS init value).
REQ-009 freq_valid  output  1  one-cycle strobe: freq_word, amp, ovf updated this cycle.
REQ-010 locked  output  1  high while the last two consecutive estimates were equal.
REQ-011 amp  output  8  peak in_mag seen during the last completed gate.
REQ-012 ovf  output  1  last estimate saturated (rounded count > 15).

Function
REQ-013 The block SHALL register in_sym and count a rising edge only when in_sym reads 0,1,1 on three consecutive cycles (2-cycle deglitch); each such pattern SHALL count once.
REQ-014 The FSM SHALL have states IDLE, GATE, REPORT; IDLE->GATE when en=1; GATE->REPORT when gate counter reaches G-1; REPORT->GATE if en=1, else IDLE.
REQ-015 In GATE the gate counter (ACC_W+AVG_LOG2 bits) SHALL increment each cycle from 0; it SHALL clear on entry to GATE.
REQ-016 Edge counter width SHALL be 4+AVG_LOG2+1 bits, clear on GATE entry, saturate at all-ones, never wrap.
REQ-017 An edge detected in the last GATE cycle SHALL be counted; edges during REPORT or IDLE SHALL be discarded.
REQ-018 In REPORT, freq_word SHALL be (edges + 2^(AVG_LOG2-1)) >> AVG_LOG2, saturated to 15; ovf=1 iff saturation applied.
REQ-019 freq_valid SHALL pulse high for exactly one cycle, the cycle after REPORT; latency from gate start to freq_valid = G+1 cycles.
REQ-020 amp SHALL be the maximum in_mag over the GATE cycles, loaded with freq_valid; running peak clears on GATE entry.
REQ-021 locked SHALL set on freq_valid when the new freq_word equals the previous one and ovf=0; clear on any freq_valid with a differing word or ovf=1.
REQ-022 en falling during GATE SHALL abort to IDLE next cycle with no freq_valid; freq_word, amp, ovf, locked hold.
REQ-023 A constant in_sym (tuning word 0) SHALL yield freq_word=0, freq_valid pulse, locked per REQ-021.
REQ-024 The first estimate after reset or abort SHALL never set locked.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, all counters 0, freq_word=0, freq_valid=0, locked=0, amp=0, ovf=0, deglitch history 0.
REQ-026 Reset asserted mid-gate SHALL discard the partial measurement; release SHALL restart from IDLE.

Structure
REQ-027 A shared package dds_pkg SHALL hold ACC_W default, the 4-bit word width constant, and the IDLE/GATE/REPORT state encoding.
REQ-028 The deglitch/rising-edge detector SHALL be a sub-module dds_edge_det (clk, rst_n, in, edge_pulse).

Verification
REQ-029 DDS with init=4'hf driving the block, en=1 -> freq_valid at cycle 1025 after gate start, freq_word=15, ovf=0; second gate -> locked=1.
REQ-030 DDS with init=4'h5 -> freq_word=5, amp=8'hff-range peak of DDS magnitude, locked after second estimate.
REQ-031 in_sym single-cycle 1 glitches every 10 cycles, otherwise 0 -> freq_word=0, no edges counted.
REQ-032 Forced square in_sym with 4-cycle half-period -> edge count 128 saturates at 127 -> freq_word=15, ovf=1, locked=0.
REQ-033 en dropped at gate cycle 500 -> no freq_valid, outputs hold; en re-raised -> full 1024-cycle gate, freq_valid, locked=0.
REQ-034 rst_n pulsed low at gate cycle 300 -> all outputs 0 asynchronously; after release next estimate correct, locked=0.
